// File: rtl/wf_bin_to_bcd_4dig_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The master side requests conversions; the slave side is the converter.
interface wf_bin_to_bcd_4dig_if #(
    parameter int BIN_W = 14
) ();
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       digit0;
    logic [3:0]       digit1;
    logic [3:0]       digit2;
    logic [3:0]       digit3;

    modport master (
        output start, bin_in,
        input  busy, done, ovf, digit0, digit1, digit2, digit3
    );

    modport slave (
        input  start, bin_in,
        output busy, done, ovf, digit0, digit1, digit2, digit3
    );
endinterface

// File: rtl/wf_bin_to_bcd_4dig.sv
// Shift-add-3 (double dabble) binary to 4-digit BCD converter; digits update only on done.
// Optional macro WF_BCD_OVF_GLYPH_EN: overflowed results show "EEEE" instead of "9999".
module wf_bin_to_bcd_4dig #(
    parameter int BIN_W = 14
) (
    input  logic                  clk,
    input  logic                  reset_n,
    wf_bin_to_bcd_4dig_if.slave   bus
);
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W - 1);

`ifdef WF_BCD_OVF_GLYPH_EN
    localparam logic [3:0] OVF_DIGIT = 4'hE;
`else
    localparam logic [3:0] OVF_DIGIT = 4'h9;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [BIN_W-1:0] shift_r;
    logic [17:0]      work_r;   // four BCD nibbles plus 2-bit ten-thousands carry
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             ovf_r;
    logic [15:0]      digits_r;

    logic [15:0]      adj_s;
    logic             ovf_s;
    logic [15:0]      res_s;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    // Add-3 correction on every BCD nibble ahead of the shift.
    always_comb begin
        adj_s = 16'd0;
        for (int i = 0; i < 4; i++) begin
            adj_s[4*i +: 4] = add3(work_r[4*i +: 4]);
        end
    end

    // Final result selection, including the overflow substitution.
    always_comb begin
        ovf_s = (work_r[17:16] != 2'b00) || (work_r[15:12] > 4'd9);
        if (ovf_s) begin
            res_s = {4{OVF_DIGIT}};
        end else begin
            res_s = work_r[15:0];
        end
    end

    // Conversion FSM with registered status and digit outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            shift_r  <= '0;
            work_r   <= 18'd0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ovf_r    <= 1'b0;
            digits_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    if (bus.start) begin
                        shift_r <= bus.bin_in;
                        work_r  <= 18'd0;
                        cnt_r   <= CNT_INIT;
                        state_r <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    busy_r  <= 1'b1;
                    done_r  <= 1'b0;
                    work_r  <= {work_r[16], adj_s, shift_r[BIN_W-1]};
                    shift_r <= {shift_r[BIN_W-2:0], 1'b0};
                    if (cnt_r == '0) begin
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    busy_r   <= 1'b1;
                    done_r   <= 1'b1;
                    ovf_r    <= ovf_s;
                    digits_r <= res_s;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.ovf    = ovf_r;
    assign bus.digit0 = digits_r[3:0];
    assign bus.digit1 = digits_r[7:4];
    assign bus.digit2 = digits_r[11:8];
    assign bus.digit3 = digits_r[15:12];
endmodule

// File: tb/tb_wf_bin_to_bcd_4dig.sv
// Directed bench for wf_bin_to_bcd_4dig: reset, conversions, boundaries, overflow,
// ignored start, back-to-back start and mid-conversion reset.
module tb_wf_bin_to_bcd_4dig;
    localparam int BIN_W = 14;

`ifdef WF_BCD_OVF_GLYPH_EN
    localparam logic [15:0] OVF_EXP = 16'hEEEE;
`else
    localparam logic [15:0] OVF_EXP = 16'h9999;
`endif

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    wf_bin_to_bcd_4dig_if #(.BIN_W(BIN_W)) bus ();

    wf_bin_to_bcd_4dig #(.BIN_W(BIN_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] digits();
        return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a conversion now; optionally pulses start with inj_val at cycle inj_at.
    task automatic run_conv(input string name, input logic [BIN_W-1:0] val,
                            input logic [15:0] exp_dig, input logic exp_ovf,
                            input int inj_at, input logic [BIN_W-1:0] inj_val);
        int cyc;
        int busy_cnt;
        bus.start  = 1'b1;
        bus.bin_in = val;
        tick();
        bus.start  = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        while (cyc < 40) begin
            if (inj_at != 0 && cyc == inj_at) begin
                bus.start  = 1'b1;
                bus.bin_in = inj_val;
            end
            tick();
            bus.start = 1'b0;
            if (inj_at != 0 && cyc == inj_at) bus.bin_in = 14'd3333;
            cyc++;
            if (bus.busy) busy_cnt++;
            if (bus.done) break;
        end
        checks++;
        if (bus.done !== 1'b1 || cyc !== 15) begin
            errors++;
            $display("FAIL %s latency: done=%b after %0d cycles, expected 1 after 15", name, bus.done, cyc);
        end
        checks++;
        if (busy_cnt !== 15) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected 15", name, busy_cnt);
        end
        checks++;
        if (digits() !== exp_dig) begin
            errors++;
            $display("FAIL %s digits: got %h expected %h", name, digits(), exp_dig);
        end
        checks++;
        if (bus.ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s ovf: got %b expected %b", name, bus.ovf, exp_ovf);
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.bin_in = 14'd0;
        tick();
        tick();
        reset_n = 1'b1;
        checks++;
        if ({bus.busy, bus.done, bus.ovf} !== 3'b000 || digits() !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: busy/done/ovf=%b digits=%h expected 000 0000",
                     {bus.busy, bus.done, bus.ovf}, digits());
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_no_done: done=%b busy=%b expected 0 0", bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_basic();
        run_conv("conv_1234", 14'd1234, 16'h1234, 1'b0, 0, 14'd0);
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || digits() !== 16'h1234) begin
            errors++;
            $display("FAIL after_done: done=%b busy=%b digits=%h expected 0 0 1234",
                     bus.done, bus.busy, digits());
        end
    endtask

    task automatic test_boundaries();
        run_conv("conv_0", 14'd0, 16'h0000, 1'b0, 0, 14'd0);
        tick();
        run_conv("conv_9999", 14'd9999, 16'h9999, 1'b0, 0, 14'd0);
        tick();
        run_conv("conv_10", 14'd10, 16'h0010, 1'b0, 0, 14'd0);
        tick();
        run_conv("conv_8090", 14'd8090, 16'h8090, 1'b0, 0, 14'd0);
        tick();
    endtask

    task automatic test_overflow();
        run_conv("conv_10000", 14'd10000, OVF_EXP, 1'b1, 0, 14'd0);
        tick();
        run_conv("conv_16383", 14'd16383, OVF_EXP, 1'b1, 0, 14'd0);
        tick();
        run_conv("conv_1_after_ovf", 14'd1, 16'h0001, 1'b0, 0, 14'd0);
        tick();
    endtask

    task automatic test_back_to_back();
        run_conv("conv_777_ignore", 14'd777, 16'h0777, 1'b0, 5, 14'd42);
        run_conv("conv_42_b2b", 14'd42, 16'h0042, 1'b0, 0, 14'd0);
        tick();
    endtask

    task automatic test_abort();
        int done_seen;
        run_conv("conv_5678", 14'd5678, 16'h5678, 1'b0, 0, 14'd0);
        tick();
        bus.start  = 1'b1;
        bus.bin_in = 14'd4321;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        checks++;
        if ({bus.busy, bus.done, bus.ovf} !== 3'b000 || digits() !== 16'h0000) begin
            errors++;
            $display("FAIL abort_state: busy/done/ovf=%b digits=%h expected 000 0000",
                     {bus.busy, bus.done, bus.ovf}, digits());
        end
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done) done_seen++;
        end
        checks++;
        if (done_seen !== 0 || digits() !== 16'h0000) begin
            errors++;
            $display("FAIL abort_no_done: done pulses=%0d digits=%h expected 0 0000", done_seen, digits());
        end
        run_conv("conv_4321", 14'd4321, 16'h4321, 1'b0, 0, 14'd0);
        tick();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        bus.start  = 1'b0;
        bus.bin_in = 14'd0;
        test_reset();
        test_basic();
        test_boundaries();
        test_overflow();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
